uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver in the debug/serial path.
- Oversamples the serial line on a baud-tick enable and deserialises LSB-first frames.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, false-start rejection, parity/framing error flags and a clean one-clock `rx_done` pulse.
- Feeds the debug unit's command decoder.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..9.
- OVERSAMPLE, 16, s_tick pulses per bit period; even, legal values 8..32.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; legal values 1 or 2.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- rx  in  1  serial input, asynchronous to clock, idle high.
- s_tick  in  1  one-clock enable pulse at OVERSAMPLE × baud rate.
- d_out  out  DATA_BITS  received data word, LSB first on the wire.
- rx_done  out  1  one-clock pulse: frame complete, d_out and flags valid.
- parity_err  out  1  parity mismatch on the last frame.
- framing_err  out  1  a stop bit sampled 0 on the last frame.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; tick counter and bit counter = 0.
  - d_out = 0, rx_done = 0, parity_err = 0, framing_err = 0, busy = 0.
  - Synchroniser flops set to 1.
  - Reset asserted mid-frame discards the partial frame; no rx_done is produced.
- Input path: rx passes through 2 flops (rx_s) before any use. All decisions use rx_s.
- State and counters advance only on clocks with s_tick = 1. rx_done is the exception: it is cleared on the very next clock regardless of s_tick.
- Tick counter `s`: $clog2(OVERSAMPLE) bits. Bit counter `n`: $clog2(DATA_BITS+1) bits.
- IDLE: on a tick with rx_s = 0 → START, s = 0.
- START: count ticks. When s = OVERSAMPLE/2 − 1 (mid start bit), sample rx_s:
  - 1: false start → IDLE; no flags change.
  - 0: → DATA, s = 0, n = 0.
- DATA: when s = OVERSAMPLE − 1, sample rx_s, s = 0, shift into a DATA_BITS shift register from the MSB side (LSB-first reception), n = n + 1.
  - After the DATA_BITS-th sample: → PARITY if PARITY_MODE ≠ 0, else → STOP.
  - Otherwise increment s.
- PARITY: sample at s = OVERSAMPLE − 1.
  - parity_pending = (XOR of data bits XOR sampled bit) ≠ (PARITY_MODE == 2).
  - Meaning: even mode requires total ones to be even; odd mode requires total ones to be odd. Mismatch sets parity_pending = 1.
  - → STOP.
- STOP: sample at s = OVERSAMPLE − 1 for each stop bit.
  - A 0 sample sets framing_pending.
  - After the last stop sample:
    - d_out ← shift register.
    - parity_err ← parity_pending; framing_err ← framing_pending.
    - rx_done = 1 for exactly one clock.
    - → IDLE.
- Flags hold until the next rx_done. Pending flags clear on START entry.
- Back-to-back frames: returning to IDLE at mid stop bit (receiver sampling is centred) lets the next start edge be detected without a lost frame.
- Break (rx held 0 through the whole frame): produces data 0, framing_err = 1, then the next frame starts immediately. No lock-up.
- Latency: rx_done rises 1 clock after the s_tick on which the last stop bit is sampled, plus 2 clocks of synchroniser delay relative to the wire.
- DATA_BITS = 9 with PARITY_MODE ≠ 0 is legal. Frame length is always 1 + DATA_BITS + (parity ? 1 : 0) + STOP_BITS bit periods.
- s_tick = 0 indefinitely: state frozen; outputs hold.

Test Plan:
- Default params. Drive 8N1 frame 0xA5 at 16× ticks → exactly one rx_done pulse; d_out = 0xA5; parity_err = 0; framing_err = 0; busy falls with rx_done.
- PARITY_MODE = 1. Send 0x07 with parity bit 0 → d_out = 0x07, parity_err = 1. Resend with parity bit 1 → parity_err = 0. Repeat with PARITY_MODE = 2: parity bit 0 → parity_err = 0.
- rx low for 4 ticks only (glitch) → returns to IDLE, no rx_done, busy high for ≤ 8 ticks; d_out and flags unchanged.
- Stop bit driven 0 on frame 0x3C → d_out = 0x3C, framing_err = 1. Next clean frame 0x11 → framing_err = 0.
- Back-to-back 0x00 then 0xFF with no idle gap; STOP_BITS = 2, DATA_BITS = 7 variant with 0x55 → two rx_done pulses, d_out sequence 0x00, 0xFF; variant d_out = 0x55.
- Assert reset low during DATA bit 4, release, send 0x81 → no rx_done for the aborted frame; all outputs 0 during reset; next frame d_out = 0x81.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width, parity and stop bits.
// Samples are centred in each bit period; rx_done is a one-clock pulse with data and flags.
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] SMid     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMax     = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] NDataEnd = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] NStopEnd = NW'(STOP_BITS - 1);
  localparam logic          ParOdd   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 parity_pend_q;
  logic                 framing_pend_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;

  // Two-flop synchroniser; reset to the idle line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      s_q            <= '0;
      n_q            <= '0;
      shreg_q        <= '0;
      parity_pend_q  <= 1'b0;
      framing_pend_q <= 1'b0;
      d_out          <= '0;
      rx_done        <= 1'b0;
      parity_err     <= 1'b0;
      framing_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (s_tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s_q) begin
              state_q        <= StStart;
              busy           <= 1'b1;
              s_q            <= '0;
              parity_pend_q  <= 1'b0;
              framing_pend_q <= 1'b0;
            end
          end
          StStart: begin
            if (s_q == SMid) begin
              if (rx_s_q) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q <= StData;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
          StData: begin
            if (s_q == SMax) begin
              s_q     <= '0;
              shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              if (n_q == NDataEnd) begin
                n_q     <= '0;
                state_q <= (PARITY_MODE != 0) ? StParity : StStop;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
          StParity: begin
            if (s_q == SMax) begin
              s_q           <= '0;
              parity_pend_q <= ((^shreg_q) ^ rx_s_q) != ParOdd;
              state_q       <= StStop;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
          StStop: begin
            if (s_q == SMax) begin
              s_q <= '0;
              if (!rx_s_q) framing_pend_q <= 1'b1;
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              if (n_q == NStopEnd) begin
                n_q         <= '0;
                d_out       <= shreg_q;
                parity_err  <= parity_pend_q;
                framing_err <= framing_pend_q | ~rx_s_q;
                rx_done     <= 1'b1;
                busy        <= 1'b0;
                state_q     <= StIdle;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: four parameter variants share clock, reset and s_tick.
module tb_uart_rx_cfg;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       s_tick;
  logic [3:0] rx_line;
  logic [3:0] rx_done_v;
  logic [3:0] pe_v;
  logic [3:0] fe_v;
  logic [3:0] busy_v;
  logic [7:0] d_out0;
  logic [7:0] d_out1;
  logic [7:0] d_out2;
  logic [6:0] d_out3;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t e0, e1, e2, e3;

  int checks = 0;
  int errors = 0;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_def (
    .clock(clock), .reset(reset), .rx(rx_line[0]), .s_tick(s_tick), .d_out(d_out0),
    .rx_done(rx_done_v[0]), .parity_err(pe_v[0]), .framing_err(fe_v[0]), .busy(busy_v[0])
  );
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
    .clock(clock), .reset(reset), .rx(rx_line[1]), .s_tick(s_tick), .d_out(d_out1),
    .rx_done(rx_done_v[1]), .parity_err(pe_v[1]), .framing_err(fe_v[1]), .busy(busy_v[1])
  );
  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
    .clock(clock), .reset(reset), .rx(rx_line[2]), .s_tick(s_tick), .d_out(d_out2),
    .rx_done(rx_done_v[2]), .parity_err(pe_v[2]), .framing_err(fe_v[2]), .busy(busy_v[2])
  );
  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_d7 (
    .clock(clock), .reset(reset), .rx(rx_line[3]), .s_tick(s_tick), .d_out(d_out3),
    .rx_done(rx_done_v[3]), .parity_err(pe_v[3]), .framing_err(fe_v[3]), .busy(busy_v[3])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // s_tick high for one clock out of every two.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clock);
      s_tick = ~s_tick;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_frame(input string name, input exp_t e, input logic [8:0] d,
                             input logic pe, input logic fe, input logic bsy);
    checks++;
    if (d !== e.data || pe !== e.pe || fe !== e.fe || bsy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got d=%h pe=%b fe=%b busy=%b want d=%h pe=%b fe=%b busy=0",
               name, d, pe, fe, bsy, e.data, e.pe, e.fe);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: rx_done pulse with no frame expected", name);
  endtask

  // Monitors: pop the expected frame whenever a receiver reports one.
  always @(negedge clock) begin
    if (rx_done_v[0]) begin
      if (q0.size() == 0) unexpected("def");
      else begin
        e0 = q0.pop_front();
        check_frame("def", e0, {1'b0, d_out0}, pe_v[0], fe_v[0], busy_v[0]);
      end
    end
    if (rx_done_v[1]) begin
      if (q1.size() == 0) unexpected("even");
      else begin
        e1 = q1.pop_front();
        check_frame("even", e1, {1'b0, d_out1}, pe_v[1], fe_v[1], busy_v[1]);
      end
    end
    if (rx_done_v[2]) begin
      if (q2.size() == 0) unexpected("odd");
      else begin
        e2 = q2.pop_front();
        check_frame("odd", e2, {1'b0, d_out2}, pe_v[2], fe_v[2], busy_v[2]);
      end
    end
    if (rx_done_v[3]) begin
      if (q3.size() == 0) unexpected("d7");
      else begin
        e3 = q3.pop_front();
        check_frame("d7", e3, {2'b0, d_out3}, pe_v[3], fe_v[3], busy_v[3]);
      end
    end
  end

  task automatic push(input int idx, input logic [8:0] data, input logic pe, input logic fe);
    exp_t e;
    e.data = data;
    e.pe   = pe;
    e.fe   = fe;
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (!s_tick) @(posedge clock);
    end
    #1;
  endtask

  // par < 0: no parity bit. A 0 stop bit is held for 12 ticks, then the line idles.
  task automatic send_frame(input int idx, input logic [8:0] data, input int dbits,
                            input int par, input int nstop, input logic stop_val);
    rx_line[idx] = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < dbits; i++) begin
      rx_line[idx] = data[i];
      wait_ticks(16);
    end
    if (par >= 0) begin
      rx_line[idx] = par[0];
      wait_ticks(16);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line[idx] = stop_val;
      wait_ticks(stop_val ? 16 : 12);
    end
    rx_line[idx] = 1'b1;
  endtask

  int busy_cnt;
  logic [8:0] abort_word;

  initial begin
    reset   = 1'b0;
    rx_line = 4'hF;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {19'b0, d_out0, pe_v[0], fe_v[0], busy_v[0], rx_done_v[0]}, 32'h0);
    reset = 1'b1;
    wait_ticks(20);

    push(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
    wait_ticks(16);

    // Short low glitch must be rejected as a false start.
    busy_cnt = 0;
    rx_line[0] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wait_ticks(1);
      if (i == 3) rx_line[0] = 1'b1;
      if (busy_v[0]) busy_cnt++;
    end
    checks++;
    if (busy_cnt < 1 || busy_cnt > 8) begin
      errors++;
      $display("FAIL glitch_busy: busy for %0d ticks, want 1..8", busy_cnt);
    end
    check("glitch_hold", {22'b0, d_out0, pe_v[0], fe_v[0]}, {22'b0, 8'hA5, 2'b00});
    check("glitch_idle", {31'b0, busy_v[0]}, 32'h0);

    push(0, 9'h03C, 1'b0, 1'b1);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b0);
    wait_ticks(24);
    push(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, -1, 1, 1'b1);
    wait_ticks(16);

    push(0, 9'h000, 1'b0, 1'b0);
    push(0, 9'h0FF, 1'b0, 1'b0);
    send_frame(0, 9'h000, 8, -1, 1, 1'b1);
    send_frame(0, 9'h0FF, 8, -1, 1, 1'b1);
    wait_ticks(16);

    push(1, 9'h007, 1'b1, 1'b0);
    send_frame(1, 9'h007, 8, 0, 1, 1'b1);
    wait_ticks(16);
    push(1, 9'h007, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1, 1'b1);
    wait_ticks(16);

    push(2, 9'h007, 1'b0, 1'b0);
    send_frame(2, 9'h007, 8, 0, 1, 1'b1);
    wait_ticks(16);
    push(2, 9'h007, 1'b1, 1'b0);
    send_frame(2, 9'h007, 8, 1, 1, 1'b1);
    wait_ticks(16);

    push(3, 9'h055, 1'b0, 1'b0);
    send_frame(3, 9'h055, 7, -1, 2, 1'b1);
    wait_ticks(16);

    // Abort a frame with reset during data bit 4; nothing may be reported for it.
    abort_word = 9'h081;
    rx_line[0] = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx_line[0] = abort_word[i];
      wait_ticks(16);
    end
    rx_line[0] = abort_word[4];
    wait_ticks(8);
    reset      = 1'b0;
    rx_line[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_mid_frame", {19'b0, d_out0, pe_v[0], fe_v[0], busy_v[0], rx_done_v[0]}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_ticks(32);
    check("after_abort_idle", {31'b0, busy_v[0]}, 32'h0);

    push(0, 9'h081, 1'b0, 1'b0);
    send_frame(0, 9'h081, 8, -1, 1, 1'b1);
    wait_ticks(16);

    check("drain_def", q0.size(), 32'd0);
    check("drain_even", q1.size(), 32'd0);
    check("drain_odd", q2.size(), 32'd0);
    check("drain_d7", q3.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
